// File: rtl/dot_product_accumulator_pkg.sv
// Shared definitions for the dot-product accumulator slice.
// Provides build-time defaults for the system-wide width macros, the
// beats-per-dot-product constant, the output-register state type, the
// score type and the saturating clamp helper. The helper is only used when
// SCORE_SATURATE_EN is defined.
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 4
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 32
`endif
`ifndef DOTP_BEATS
`define DOTP_BEATS (`MAX_EMBEDDING_DIM/8)
`endif

package dot_product_accumulator_pkg;

  // Beats that make up one full QK dot product.
  localparam int DOTP_BEATS = `DOTP_BEATS;

  // Default score width for the default IN_LEN of 4 partial sums per beat.
  localparam int SCORE_W = 2*`INTEGER_WIDTH + 1 + $clog2(4) + $clog2(DOTP_BEATS);

  typedef logic signed [SCORE_W-1:0] score_t;

  // Output register occupancy.
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Clamp a signed value into the range of a signed integer that is `width` bits wide.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      res = hi;
    end else if (value < lo) begin
      res = lo;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Beat input and score output handshake bundle for dot_product_accumulator.
// The master modport is the side that feeds beats and consumes scores.
// The slave modport is the accumulator itself.
interface dot_product_accumulator_if
  import dot_product_accumulator_pkg::*;
#(
  parameter int IN_LEN = 4,
  parameter int W_IN   = 2*`INTEGER_WIDTH + 1,
  parameter int W_OUT  = SCORE_W,
  parameter int BEAT_W = 2
);
  logic                    vld_in;
  logic                    rdy_out;
  logic signed [W_IN-1:0]  list_in [IN_LEN];
  logic                    vld_out;
  logic                    rdy_in;
  logic signed [W_OUT-1:0] score_out;
  logic [BEAT_W-1:0]       beat_idx;

  modport master (
    output vld_in, list_in, rdy_in,
    input  rdy_out, vld_out, score_out, beat_idx
  );

  modport slave (
    input  vld_in, list_in, rdy_in,
    output rdy_out, vld_out, score_out, beat_idx
  );
endinterface

// File: rtl/dot_product_accumulator_beat_adder_tree.sv
// Combinational sum of one beat's partial sums.
// Each input is sign-extended to the accumulator width before it is added,
// so the result cannot overflow.
module beat_adder_tree #(
  parameter int IN_LEN = 4,
  parameter int W_IN   = 9,
  parameter int W_ACC  = 13
) (
  input  logic signed [W_IN-1:0]  list_in [IN_LEN],
  output logic signed [W_ACC-1:0] beat_sum
);
  logic signed [W_ACC-1:0] ext [IN_LEN];

  for (genvar gi = 0; gi < IN_LEN; gi++) begin : g_ext
    assign ext[gi] = W_ACC'(list_in[gi]);
  end

  // Add all sign-extended partial sums together.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < IN_LEN; i++) begin
      beat_sum = beat_sum + ext[i];
    end
  end
endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates NUM_BEATS beats of IN_LEN signed partial sums into one
// dot-product score. The score is presented through a held output register,
// so the next vector can accumulate while a score waits.
// Optional feature: SCORE_SATURATE_EN clamps the final result to W_OUT bits.
// Without it, the low W_OUT bits are kept and the value wraps.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int IN_LEN    = 4,
  parameter int W_IN      = 2*`INTEGER_WIDTH + 1,
  parameter int NUM_BEATS = DOTP_BEATS,
  parameter int W_ACC     = W_IN + $clog2(IN_LEN) + $clog2(NUM_BEATS),
  parameter int W_OUT     = W_ACC,
  parameter int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input logic clk,
  input logic rst,
  dot_product_accumulator_if.slave bus
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  out_state_t              state_reg, state_next;
  logic signed [W_ACC-1:0] acc_reg, acc_next;
  logic [BEAT_W-1:0]       beat_cnt_reg, beat_cnt_next;
  logic signed [W_OUT-1:0] out_reg, out_next;

  logic signed [W_ACC-1:0] beat_sum;
  logic signed [W_ACC-1:0] total;
  logic signed [W_OUT-1:0] score_load;
  logic                    is_last;
  logic                    accept;

  beat_adder_tree #(
    .IN_LEN (IN_LEN),
    .W_IN   (W_IN),
    .W_ACC  (W_ACC)
  ) u_beat_adder_tree (
    .list_in  (bus.list_in),
    .beat_sum (beat_sum)
  );

  assign is_last = (beat_cnt_reg == LAST_BEAT);
  assign total   = acc_reg + beat_sum;

`ifdef SCORE_SATURATE_EN
  assign score_load = W_OUT'(sat_signed(64'(total), W_OUT));
`else
  assign score_load = W_OUT'(total);
`endif

  // Only a final beat stalls, and only while an unconsumed score is still held.
  // This keeps rdy_out independent of vld_in.
  assign bus.rdy_out = !((state_reg == OUT_FULL) && !bus.rdy_in && is_last);
  assign accept      = bus.vld_in && bus.rdy_out;

  assign bus.vld_out   = (state_reg == OUT_FULL);
  assign bus.score_out = out_reg;
  assign bus.beat_idx  = beat_cnt_reg;

  // Next state: drain the held score, then accumulate or load the score from an accepted beat.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    beat_cnt_next = beat_cnt_reg;
    out_next      = out_reg;
    if ((state_reg == OUT_FULL) && bus.rdy_in) begin
      state_next = OUT_EMPTY;
    end
    if (accept) begin
      if (is_last) begin
        out_next      = score_load;
        acc_next      = '0;
        beat_cnt_next = '0;
        state_next    = OUT_FULL;
      end else begin
        acc_next      = total;
        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
      end
    end
  end

  // State register; reset discards any partial vector and any held score.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= OUT_EMPTY;
      acc_reg      <= '0;
      beat_cnt_reg <= '0;
      out_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      beat_cnt_reg <= beat_cnt_next;
      out_reg      <= out_next;
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator.
// Two instances share the same stimulus:
//  - the default build, with a 13-bit score;
//  - a 12-bit-score build, which exercises the narrowed result in wrap or saturate mode.
// A score-level model is compared against the outputs of both instances on every cycle.
// Directed checkpoints carry hand-computed literal expectations.
module tb_dot_product_accumulator;
  localparam int IN_LEN = 4;
  localparam int W_IN   = 9;
  localparam int NB     = 4;
  localparam int W_MAIN = 13;
  localparam int W_NAR  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic vld = 1'b0;
  logic rdy = 1'b1;
  int   lst [IN_LEN];

  dot_product_accumulator_if #(.IN_LEN(IN_LEN), .W_IN(W_IN), .W_OUT(W_MAIN), .BEAT_W(2)) if_main ();
  dot_product_accumulator_if #(.IN_LEN(IN_LEN), .W_IN(W_IN), .W_OUT(W_NAR),  .BEAT_W(2)) if_nar ();

  assign if_main.vld_in = vld;
  assign if_nar.vld_in  = vld;
  assign if_main.rdy_in = rdy;
  assign if_nar.rdy_in  = rdy;
  for (genvar gi = 0; gi < IN_LEN; gi++) begin : g_drv
    assign if_main.list_in[gi] = W_IN'(lst[gi]);
    assign if_nar.list_in[gi]  = W_IN'(lst[gi]);
  end

  dot_product_accumulator #(.IN_LEN(IN_LEN), .W_IN(W_IN), .NUM_BEATS(NB)) u_main (
    .clk (clk),
    .rst (rst),
    .bus (if_main)
  );

  dot_product_accumulator #(.IN_LEN(IN_LEN), .W_IN(W_IN), .NUM_BEATS(NB), .W_OUT(W_NAR)) u_nar (
    .clk (clk),
    .rst (rst),
    .bus (if_nar)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed interpretation of the low w bits of x.
  function automatic longint wrap_s(input longint x, input int w);
    longint m;
    longint r;
    m = longint'(1) <<< w;
    r = x % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint sat_s(input longint x, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic longint narrow(input longint x);
`ifdef SCORE_SATURATE_EN
    return sat_s(x, W_NAR);
`else
    return wrap_s(x, W_NAR);
`endif
  endfunction

  // Score-level model: beats seen so far, running sum, and the held score.
  int     m_cnt   = 0;
  longint m_acc   = 0;
  longint m_score = 0;
  bit     m_full  = 1'b0;
  longint m_bsum;
  bit     m_rdy;

  // Per-cycle comparison on the falling edge, then advance the model across the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      m_cnt = 0; m_acc = 0; m_score = 0; m_full = 1'b0;
    end
    m_rdy = !(m_full && !rdy && (m_cnt == NB - 1));
    check("main.rdy_out",   longint'(if_main.rdy_out),   longint'(m_rdy));
    check("main.vld_out",   longint'(if_main.vld_out),   longint'(m_full));
    check("main.score_out", longint'(if_main.score_out), m_score);
    check("main.beat_idx",  longint'(if_main.beat_idx),  longint'(m_cnt));
    check("nar.rdy_out",    longint'(if_nar.rdy_out),    longint'(m_rdy));
    check("nar.vld_out",    longint'(if_nar.vld_out),    longint'(m_full));
    check("nar.score_out",  longint'(if_nar.score_out),  narrow(m_score));
    if (rst) begin
      if (m_full && rdy) m_full = 1'b0;
      if (vld && m_rdy) begin
        m_bsum = 0;
        for (int i = 0; i < IN_LEN; i++) m_bsum = m_bsum + longint'(lst[i]);
        if (m_cnt == NB - 1) begin
          m_score = m_acc + m_bsum;
          m_acc   = 0;
          m_cnt   = 0;
          m_full  = 1'b1;
        end else begin
          m_acc = m_acc + m_bsum;
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // Drive one beat (or an idle cycle) and return just after the rising edge.
  task automatic step(input int a, input int b, input int c, input int d, input bit v);
    lst[0] = a; lst[1] = b; lst[2] = c; lst[3] = d;
    vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < IN_LEN; i++) lst[i] = 0;
    #2;
    check("reset vld_out",   longint'(if_main.vld_out),   0);
    check("reset score_out", longint'(if_main.score_out), 0);
    check("reset beat_idx",  longint'(if_main.beat_idx),  0);
    check("reset rdy_out",   longint'(if_main.rdy_out),   1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    // Single vector: 10 + 26 - 4 + 10 = 42.
    step(1, 2, 3, 4, 1'b1);
    step(5, 6, 7, 8, 1'b1);
    step(-1, -1, -1, -1, 1'b1);
    step(0, 0, 0, 10, 1'b1);
    check("vec1 vld_out", longint'(if_main.vld_out), 1);
    check("vec1 score",   longint'(if_main.score_out), 42);
    idle();
    check("vec1 vld one cycle", longint'(if_main.vld_out), 0);

    // Back-to-back vectors: 16, then 32.
    for (int k = 0; k < 4; k++) step(1, 1, 1, 1, 1'b1);
    check("b2b score A", longint'(if_main.score_out), 16);
    check("b2b rdy A",   longint'(if_main.rdy_out), 1);
    for (int k = 0; k < 4; k++) step(2, 2, 2, 2, 1'b1);
    check("b2b score B", longint'(if_main.score_out), 32);
    check("b2b vld B",   longint'(if_main.vld_out), 1);

    // Stall: score 12 held while the next vector (sum 10) waits on its last beat.
    for (int k = 0; k < 4; k++) step(3, 0, 0, 0, 1'b1);
    rdy = 1'b0;
    step(1, 0, 0, 0, 1'b1);
    step(0, 2, 0, 0, 1'b1);
    step(0, 0, 3, 0, 1'b1);
    lst[0] = 0; lst[1] = 0; lst[2] = 0; lst[3] = 4;
    #1;
    check("stall rdy_out", longint'(if_main.rdy_out), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall score held", longint'(if_main.score_out), 12);
    check("stall vld held",   longint'(if_main.vld_out), 1);
    check("stall beat_idx",   longint'(if_main.beat_idx), 3);
    rdy = 1'b1;
    #1;
    check("release rdy_out", longint'(if_main.rdy_out), 1);
    @(posedge clk); #1;
    check("release score", longint'(if_main.score_out), 10);
    check("release vld",   longint'(if_main.vld_out), 1);
    idle();
    check("release drained", longint'(if_main.vld_out), 0);

    // Asynchronous reset in the middle of a vector.
    step(5, 5, 5, 5, 1'b1);
    step(5, 5, 5, 5, 1'b1);
    vld = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async score",    longint'(if_main.score_out), 0);
    check("async beat_idx", longint'(if_main.beat_idx), 0);
    check("async vld_out",  longint'(if_main.vld_out), 0);
    check("async rdy_out",  longint'(if_main.rdy_out), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    step(1, 1, 1, 1, 1'b1);
    step(2, 2, 2, 2, 1'b1);
    step(0, 0, 0, 0, 1'b1);
    step(0, 0, 0, 1, 1'b1);
    check("post-reset score", longint'(if_main.score_out), 13);

    // Negative extreme: 16 * -256 = -4096 fits 13 bits exactly.
    for (int k = 0; k < 4; k++) step(-256, -256, -256, -256, 1'b1);
    check("neg extreme", longint'(if_main.score_out), -4096);

    // Positive extreme: 16 * 255 = 4080 overflows a 12-bit score.
    for (int k = 0; k < 4; k++) step(255, 255, 255, 255, 1'b1);
    check("pos extreme main", longint'(if_main.score_out), 4080);
`ifdef SCORE_SATURATE_EN
    check("pos extreme narrow", longint'(if_nar.score_out), 2047);
`else
    check("pos extreme narrow", longint'(if_nar.score_out), -16);
`endif
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
